// File: rtl/cpuif_axi_manager_if.sv
`default_nettype none
// ============================================================================
// Module      : cpuif_axi_manager_if
// Description : AXI4 bus bundle between the CSR-to-AXI bridge (master modport)
//               and a subordinate (slave modport). Signal names keep the
//               bridge-side direction suffixes so they read the same on both
//               ends of the link.
// Ports       : AR/R/AW/W/B channel signals, parameterised widths.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpuif_axi_manager_if #(
    parameter int AxiDataWidth = 64,
    parameter int AxiAddrWidth = 32,
    parameter int AxiIdWidth   = 8,
    parameter int AxiUserWidth = 32
);
    // AR channel
    logic [AxiAddrWidth-1:0]   araddr_o;
    logic [2:0]                arsize_o;
    logic [7:0]                arlen_o;
    logic [1:0]                arburst_o;
    logic [AxiIdWidth-1:0]     arid_o;
    logic [AxiUserWidth-1:0]   aruser_o;
    logic                      arlock_o;
    logic                      arvalid_o;
    logic                      arready_i;
    // R channel
    logic [AxiDataWidth-1:0]   rdata_i;
    logic [1:0]                rresp_i;
    logic [AxiIdWidth-1:0]     rid_i;
    logic                      rlast_i;
    logic                      rvalid_i;
    logic                      rready_o;
    // AW channel
    logic [AxiAddrWidth-1:0]   awaddr_o;
    logic [2:0]                awsize_o;
    logic [7:0]                awlen_o;
    logic [1:0]                awburst_o;
    logic [AxiIdWidth-1:0]     awid_o;
    logic [AxiUserWidth-1:0]   awuser_o;
    logic                      awlock_o;
    logic                      awvalid_o;
    logic                      awready_i;
    // W channel
    logic [AxiDataWidth-1:0]   wdata_o;
    logic [AxiDataWidth/8-1:0] wstrb_o;
    logic [AxiUserWidth-1:0]   wuser_o;
    logic                      wlast_o;
    logic                      wvalid_o;
    logic                      wready_i;
    // B channel
    logic [1:0]                bresp_i;
    logic [AxiIdWidth-1:0]     bid_i;
    logic                      bvalid_i;
    logic                      bready_o;

    modport master (
        output araddr_o, arsize_o, arlen_o, arburst_o, arid_o, aruser_o, arlock_o, arvalid_o,
        input  arready_i,
        input  rdata_i, rresp_i, rid_i, rlast_i, rvalid_i,
        output rready_o,
        output awaddr_o, awsize_o, awlen_o, awburst_o, awid_o, awuser_o, awlock_o, awvalid_o,
        input  awready_i,
        output wdata_o, wstrb_o, wuser_o, wlast_o, wvalid_o,
        input  wready_i,
        input  bresp_i, bid_i, bvalid_i,
        output bready_o
    );

    modport slave (
        input  araddr_o, arsize_o, arlen_o, arburst_o, arid_o, aruser_o, arlock_o, arvalid_o,
        output arready_i,
        output rdata_i, rresp_i, rid_i, rlast_i, rvalid_i,
        input  rready_o,
        input  awaddr_o, awsize_o, awlen_o, awburst_o, awid_o, awuser_o, awlock_o, awvalid_o,
        output awready_i,
        input  wdata_o, wstrb_o, wuser_o, wlast_o, wvalid_o,
        output wready_i,
        output bresp_i, bid_i, bvalid_i,
        input  bready_o
    );
endinterface
`default_nettype wire

// File: rtl/cpuif_axi_manager.sv
`default_nettype none
// ============================================================================
// Module      : cpuif_axi_manager
// Description : Bridges a simple CSR request/ack port onto single-beat AXI4
//               reads and writes, one transaction in flight at a time.
// Ports       : clk_i / rst_i      - clock, synchronous active-high reset
//               s_cpuif_*          - CSR request, write data, ack/err/rd_data
//               axi (master)       - AR/R/AW/W/B channels
// Revision    : 1.0 - initial release
// ============================================================================
module cpuif_axi_manager #(
    parameter int                      CsrAddrWidth = 12,
    parameter int                      CsrDataWidth = 32,
    parameter int                      AxiDataWidth = 64,
    parameter int                      AxiAddrWidth = 32,
    parameter int                      AxiIdWidth   = 8,
    parameter int                      AxiUserWidth = 32,
    parameter logic [AxiIdWidth-1:0]   TxnId        = '0,
    parameter logic [AxiUserWidth-1:0] TxnUser      = '0,
    parameter logic [AxiAddrWidth-1:0] BaseAddr     = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    s_cpuif_req,
    input  logic                    s_cpuif_req_is_wr,
    input  logic [CsrAddrWidth-1:0] s_cpuif_addr,
    input  logic [CsrDataWidth-1:0] s_cpuif_wr_data,
    input  logic [CsrDataWidth-1:0] s_cpuif_wr_biten,
    output logic                    s_cpuif_req_stall_wr,
    output logic                    s_cpuif_req_stall_rd,
    output logic                    s_cpuif_rd_ack,
    output logic                    s_cpuif_rd_err,
    output logic [CsrDataWidth-1:0] s_cpuif_rd_data,
    output logic                    s_cpuif_wr_ack,
    output logic                    s_cpuif_wr_err,
    cpuif_axi_manager_if.master     axi
);
    localparam int C_CSR_BYTES  = CsrDataWidth / 8;
    localparam int C_CSR_OFS_W  = $clog2(C_CSR_BYTES);
    localparam int C_LANES      = AxiDataWidth / CsrDataWidth;
    localparam int C_LANE_IDX_W = (C_LANES > 1) ? $clog2(C_LANES) : 1;
    localparam int C_STRB_W     = AxiDataWidth / 8;
    localparam logic [CsrAddrWidth-1:0] C_ADDR_MASK = ~CsrAddrWidth'((1 << C_CSR_OFS_W) - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        ACK     = 3'd5
    } state_t;

    state_t                  state_q,   state_d;
    logic [CsrAddrWidth-1:0] addr_q,    addr_d;
    logic [CsrDataWidth-1:0] wr_data_q, wr_data_d;
    logic [CsrDataWidth-1:0] biten_q,   biten_d;
    logic                    is_wr_q,   is_wr_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q,  w_done_d;
    logic                    err_q,     err_d;
    logic [CsrDataWidth-1:0] rdata_q,   rdata_d;

    logic [C_LANE_IDX_W-1:0] w_lane;
    logic [CsrDataWidth-1:0] w_rd_lane;
    logic [C_CSR_BYTES-1:0]  w_csr_strb;
    logic                    w_rd_err;
    logic                    w_wr_err;

    // CSR-word lane inside the wider AXI beat, taken from the address bits
    // just above the CSR byte offset.
    assign w_lane    = C_LANE_IDX_W'((addr_q >> C_CSR_OFS_W) % C_LANES);
    assign w_rd_lane = CsrDataWidth'(axi.rdata_i >> (w_lane * CsrDataWidth));
    assign w_rd_err  = axi.rresp_i[1] || (axi.rid_i != TxnId) || !axi.rlast_i;
    assign w_wr_err  = axi.bresp_i[1] || (axi.bid_i != TxnId);

    // A byte strobe is set if any bit enable within that byte is set.
    always_comb begin
        w_csr_strb = '0;
        for (int k = 0; k < C_CSR_BYTES; k++) begin
            w_csr_strb[k] = |s_cpuif_biten_slice(biten_q, k);
        end
    end

    function automatic logic [7:0] s_cpuif_biten_slice(input logic [CsrDataWidth-1:0] be, input int k);
        return be[8*k +: 8];
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wr_data_q <= '0;
            biten_q   <= '0;
            is_wr_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            biten_q   <= biten_d;
            is_wr_q   <= is_wr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        biten_d   = biten_q;
        is_wr_d   = is_wr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (s_cpuif_req) begin
                    addr_d    = s_cpuif_addr;
                    wr_data_d = s_cpuif_wr_data;
                    biten_d   = s_cpuif_wr_biten;
                    is_wr_d   = s_cpuif_req_is_wr;
                    err_d     = 1'b0;
                    state_d   = s_cpuif_req_is_wr ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (axi.arready_i) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (axi.rvalid_i) begin
                    rdata_d = w_rd_lane;
                    err_d   = w_rd_err;
                    state_d = ACK;
                end
            end
            WR_REQ: begin
                // Each valid is only high while its done flag is clear, so a
                // ready seen after completion cannot re-handshake.
                aw_done_d = aw_done_q || axi.awready_i;
                w_done_d  = w_done_q  || axi.wready_i;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: begin
                if (axi.bvalid_i) begin
                    err_d   = w_wr_err;
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // CSR side
    assign s_cpuif_req_stall_wr = (state_q != IDLE);
    assign s_cpuif_req_stall_rd = (state_q != IDLE);
    assign s_cpuif_rd_ack       = (state_q == ACK) && !is_wr_q;
    assign s_cpuif_wr_ack       = (state_q == ACK) &&  is_wr_q;
    assign s_cpuif_rd_err       = s_cpuif_rd_ack && err_q;
    assign s_cpuif_wr_err       = s_cpuif_wr_ack && err_q;
    assign s_cpuif_rd_data      = s_cpuif_rd_ack ? rdata_q : '0;

    // AR / R
    assign axi.araddr_o  = BaseAddr + AxiAddrWidth'(addr_q & C_ADDR_MASK);
    assign axi.arsize_o  = 3'(C_CSR_OFS_W);
    assign axi.arlen_o   = 8'd0;
    assign axi.arburst_o = 2'b01;
    assign axi.arid_o    = TxnId;
    assign axi.aruser_o  = TxnUser;
    assign axi.arlock_o  = 1'b0;
    assign axi.arvalid_o = (state_q == RD_ADDR);
    assign axi.rready_o  = (state_q == RD_DATA);

    // AW / W / B
    assign axi.awaddr_o  = BaseAddr + AxiAddrWidth'(addr_q & C_ADDR_MASK);
    assign axi.awsize_o  = 3'(C_CSR_OFS_W);
    assign axi.awlen_o   = 8'd0;
    assign axi.awburst_o = 2'b01;
    assign axi.awid_o    = TxnId;
    assign axi.awuser_o  = TxnUser;
    assign axi.awlock_o  = 1'b0;
    assign axi.awvalid_o = (state_q == WR_REQ) && !aw_done_q;
    assign axi.wvalid_o  = (state_q == WR_REQ) && !w_done_q;
    assign axi.wdata_o   = AxiDataWidth'(wr_data_q) << (w_lane * CsrDataWidth);
    assign axi.wstrb_o   = C_STRB_W'(w_csr_strb) << (w_lane * C_CSR_BYTES);
    assign axi.wuser_o   = TxnUser;
    assign axi.wlast_o   = 1'b1;
    assign axi.bready_o  = (state_q == WR_RESP);
endmodule
`default_nettype wire
